keypad_access_ctrl: RTL and testbench

- Access controller that consumes decoded key presses from the keypad scanner and sequences PIN entry, verification, door unlock, failed-attempt lockout and PIN reprogramming.
- Sits between the keypad scanner and the door-actuator/alarm drivers in the smart-home top level.
- Holds the active PIN in registers; there is no non-volatile storage.

---
 rtl/keypad_pkg.sv | 17 +
 rtl/key_event_detect.sv | 30 +++
 rtl/keypad_access_ctrl.sv | 135 +++++++++++++
 tb/tb_keypad_access_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared key codes and controller state encoding for the keypad scanner and access controller.
package keypad_pkg;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;
  localparam logic [3:0] KEY_NONE = 4'd15;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CHECK   = 3'd2,
    UNLOCK  = 3'd3,
    PROG    = 3'd4,
    LOCKOUT = 3'd5
  } state_e;

endpackage

// File: rtl/key_event_detect.sv
// Turns the scanner's level-held key_valid into one strobe per press, classified as digit, '*' or '#'.
// Strobes are combinational off the current key_value; codes 12-15 never strobe.
module key_event_detect
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_value_i,
  input  logic       key_valid_i,
  output logic       is_digit_o,
  output logic       is_star_o,
  output logic       is_hash_o,
  output logic [3:0] digit_o
);

  logic valid_q;
  logic press;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) valid_q <= 1'b0;
    else       valid_q <= key_valid_i;
  end

  assign press      = key_valid_i & ~valid_q;
  assign is_digit_o = press && (key_value_i <= 4'd9);
  assign is_star_o  = press && (key_value_i == KEY_STAR);
  assign is_hash_o  = press && (key_value_i == KEY_HASH);
  assign digit_o    = key_value_i;

endmodule

// File: rtl/keypad_access_ctrl.sv
// PIN entry / verify / unlock / lockout / reprogram controller; all status outputs registered,
// so each asserts the cycle after the edge that decided it.
module keypad_access_ctrl
  import keypad_pkg::*;
#(
  parameter int                   PIN_LEN     = 4,
  parameter logic [4*PIN_LEN-1:0] DEFAULT_PIN = 16'h1234,
  parameter int                   TIMEOUT_CYC = 500000,
  parameter int                   UNLOCK_CYC  = 1000000,
  parameter int                   LOCKOUT_CYC = 5000000,
  parameter int                   MAX_FAIL    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_value,
  input  logic       key_valid,
  output logic       unlock,
  output logic       alarm,
  output logic       bad_pin,
  output logic       code_saved,
  output logic [2:0] digit_count,
  output logic [2:0] state_o
);

  localparam int MAX_A   = (TIMEOUT_CYC > UNLOCK_CYC) ? TIMEOUT_CYC : UNLOCK_CYC;
  localparam int MAX_CYC = (MAX_A > LOCKOUT_CYC) ? MAX_A : LOCKOUT_CYC;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam int FW      = (MAX_FAIL < 2) ? 1 : $clog2(MAX_FAIL + 1);
  localparam int BW      = 4 * PIN_LEN;

  logic          ev_digit, ev_star, ev_hash;
  logic [3:0]    ev_val;
  state_e        state_q, state_d;
  logic [TW-1:0] timer_q;
  logic [BW-1:0] buf_q, code_q;
  logic [2:0]    cnt_q;
  logic [FW-1:0] fail_q;
  logic          unlock_q, alarm_q, bad_pin_q, code_saved_q;

  logic expiry, pin_full, match, last_fail, dig_acc, prog_hash, clear_buf, timer_load;

  key_event_detect u_kev (
    .clk         (clk),
    .reset       (reset),
    .key_value_i (key_value),
    .key_valid_i (key_valid),
    .is_digit_o  (ev_digit),
    .is_star_o   (ev_star),
    .is_hash_o   (ev_hash),
    .digit_o     (ev_val)
  );

  function automatic logic [TW-1:0] cyc_load(input state_e s);
    case (s)
      ENTRY, PROG: return TW'(TIMEOUT_CYC - 1);
      UNLOCK:      return TW'(UNLOCK_CYC - 1);
      LOCKOUT:     return TW'(LOCKOUT_CYC - 1);
      default:     return '0;
    endcase
  endfunction

  // A timer expiry outranks any key event arriving in the same cycle.
  assign expiry    = (timer_q == '0) &&
                     (state_q == ENTRY || state_q == UNLOCK || state_q == PROG || state_q == LOCKOUT);
  assign pin_full  = (cnt_q == 3'(PIN_LEN));
  assign match     = pin_full && (buf_q == code_q);
  assign last_fail = (int'(fail_q) + 1) >= MAX_FAIL;
  assign dig_acc   = ev_digit && !expiry && !pin_full &&
                     (state_q == IDLE || state_q == ENTRY || state_q == PROG);
  assign prog_hash = (state_q == PROG) && ev_hash && !expiry;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ev_digit) state_d = ENTRY;
      ENTRY:   if (expiry || ev_star) state_d = IDLE;
               else if (ev_hash)      state_d = CHECK;
      CHECK:   state_d = match ? UNLOCK : (last_fail ? LOCKOUT : IDLE);
      UNLOCK:  if (expiry || ev_star) state_d = IDLE;
               else if (ev_hash)      state_d = PROG;
      PROG:    if (expiry || ev_star || ev_hash) state_d = IDLE;
      LOCKOUT: if (expiry) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The buffer also empties on entering UNLOCK so PROG starts from a blank entry.
  assign clear_buf  = (state_d != state_q) &&
                      (state_d == IDLE || state_d == UNLOCK || state_d == LOCKOUT);
  assign timer_load = (state_d != state_q) ||
                      ((state_q == ENTRY || state_q == PROG) && !expiry && (ev_digit || ev_star || ev_hash));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      buf_q        <= '0;
      code_q       <= DEFAULT_PIN;
      cnt_q        <= '0;
      fail_q       <= '0;
      unlock_q     <= 1'b0;
      alarm_q      <= 1'b0;
      bad_pin_q    <= 1'b0;
      code_saved_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      unlock_q     <= (state_d == UNLOCK);
      alarm_q      <= (state_d == LOCKOUT);
      bad_pin_q    <= ((state_q == CHECK) && !match) || (prog_hash && !pin_full);
      code_saved_q <= prog_hash && pin_full;
      if (prog_hash && pin_full) code_q <= buf_q;

      if (timer_load)          timer_q <= cyc_load(state_d);
      else if (timer_q != '0)  timer_q <= timer_q - 1'b1;

      if (clear_buf) begin
        buf_q <= '0;
        cnt_q <= '0;
      end else if (dig_acc) begin
        buf_q <= (buf_q << 4) | BW'(ev_val);
        cnt_q <= cnt_q + 3'd1;
      end

      if (state_q == CHECK) fail_q <= (match || last_fail) ? '0 : fail_q + 1'b1;
    end
  end

  assign unlock      = unlock_q;
  assign alarm       = alarm_q;
  assign bad_pin     = bad_pin_q;
  assign code_saved  = code_saved_q;
  assign digit_count = cnt_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_keypad_access_ctrl.sv
// Randomised bench: attempts are scored against a PIN-level model; a monitor checks observed events.
module tb_keypad_access_ctrl;
  import keypad_pkg::*;

  localparam int PL = 4, TO = 50, UC = 20, LC = 100, MF = 3;
  localparam int EV_UNLOCK = 1, EV_BAD = 2, EV_SAVED = 3, EV_ALARM = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] key_value = 4'd15;
  logic       key_valid = 1'b0;
  logic       unlock, alarm, bad_pin, code_saved;
  logic [2:0] digit_count, state_o;

  keypad_access_ctrl #(
    .PIN_LEN(PL), .DEFAULT_PIN(16'h1234), .TIMEOUT_CYC(TO),
    .UNLOCK_CYC(UC), .LOCKOUT_CYC(LC), .MAX_FAIL(MF)
  ) dut (
    .clk(clk), .reset(reset), .key_value(key_value), .key_valid(key_valid),
    .unlock(unlock), .alarm(alarm), .bad_pin(bad_pin), .code_saved(code_saved),
    .digit_count(digit_count), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int len;   // -1: cut short (between 1 and full duration - 1)
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  model_code[4] = '{1, 2, 3, 4};
  int  model_fails = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic expect_ev(input int kind, input int len);
    ev_t e;
    e.kind = kind;
    e.len  = len;
    exp_q.push_back(e);
  endtask

  task automatic got(input int kind, input int len);
    ev_t e;
    int  full;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got kind %0d len %0d, expected nothing", kind, len);
      return;
    end
    e = exp_q.pop_front();
    full = (e.kind == EV_ALARM) ? LC : UC;
    if (e.kind != kind || (e.len >= 0 && len != e.len) || (e.len < 0 && (len < 1 || len >= full))) begin
      failures++;
      $display("FAIL event: got kind %0d len %0d, expected kind %0d len %0d", kind, len, e.kind, e.len);
    end
  endtask

  // Monitor: reports pulses immediately and unlock/alarm windows when they close.
  initial begin
    int   ulen, alen;
    logic u_prev, a_prev;
    ulen = 0; alen = 0; u_prev = 1'b0; a_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bad_pin)    got(EV_BAD, 0);
      if (code_saved) got(EV_SAVED, 0);
      if (unlock) ulen++;
      else if (u_prev) begin got(EV_UNLOCK, ulen); ulen = 0; end
      if (alarm) alen++;
      else if (a_prev) begin got(EV_ALARM, alen); alen = 0; end
      u_prev = unlock;
      a_prev = alarm;
    end
  end

  task automatic press(input int k, input int hold);
    @(posedge clk); #1;
    key_value = 4'(k);
    key_valid = 1'b1;
    repeat (hold) @(posedge clk);
    #1 key_valid = 1'b0;
    repeat ($urandom_range(1, 3)) @(posedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (state_o != 3'd0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (state_o != 3'd0) begin
      failures++;
      $display("FAIL wait_idle: state %0d after %0d cycles, expected 0", state_o, budget);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2 reset = 1'b1;
    @(negedge clk);
    chk("rst_unlock", unlock, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_state", state_o, 0);
    chk("rst_count", digit_count, 0);
    @(posedge clk); #1 reset = 1'b0;
    model_code  = '{1, 2, 3, 4};
    model_fails = 0;
  endtask

  // action: 0 wait unlock out, 1 '*' relock, 2 reprogram with p/pn, 3 reset mid unlock/lockout
  task automatic attempt(input int d[8], input int n, input int action, input int p[8], input int pn);
    bit match, lock;
    match = (n >= PL);
    for (int i = 0; i < PL; i++) if (i < n && d[i] != model_code[i]) match = 0;
    lock = 0;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) press($urandom_range(12, 15), $urandom_range(1, 3));
      press(d[i], $urandom_range(1, 4));
    end
    if (n > 0) begin
      if (match) begin
        model_fails = 0;
        expect_ev(EV_UNLOCK, (action == 0) ? UC : -1);
      end else begin
        model_fails++;
        expect_ev(EV_BAD, 0);
        if (model_fails == MF) begin
          lock = 1;
          model_fails = 0;
          expect_ev(EV_ALARM, (action == 3) ? -1 : LC);
        end
      end
    end
    @(posedge clk); #1;
    key_value = KEY_HASH;
    key_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("after_hash_state", state_o, (n > 0) ? 2 : 0);
    @(negedge clk);
    if (n > 0) begin
      chk("verdict_state", state_o, match ? 3 : (lock ? 5 : 0));
      chk("verdict_pulse", match ? unlock : bad_pin, 1);
    end
    @(posedge clk); #1 key_valid = 1'b0;
    repeat (2) @(posedge clk);
    if (lock) begin
      press(1, 2); press(2, 1); press(3, 2); press(4, 1); press(KEY_HASH, 2);
      if (action == 3) do_reset();
      else wait_idle(LC + 20);
    end else if (n > 0 && match) begin
      if (action == 1) begin
        press(KEY_STAR, 2);
      end else if (action == 2) begin
        press(KEY_HASH, 2);
        for (int i = 0; i < pn; i++) press(p[i], $urandom_range(1, 3));
        if (pn >= PL) begin
          for (int i = 0; i < PL; i++) model_code[i] = p[i];
          expect_ev(EV_SAVED, 0);
        end else begin
          expect_ev(EV_BAD, 0);
        end
        press(KEY_HASH, 2);
      end else if (action == 3) begin
        repeat (3) @(posedge clk);
        do_reset();
      end
      wait_idle(UC + 20);
    end
    chk("end_count", digit_count, 0);
  endtask

  initial begin
    int d[8], p[8], n, pn, act;
    p = '{9, 8, 7, 6, 0, 0, 0, 0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_unlock", unlock, 0);
    chk("reset_alarm", alarm, 0);
    chk("reset_bad_pin", bad_pin, 0);
    chk("reset_code_saved", code_saved, 0);
    chk("reset_count", digit_count, 0);
    chk("reset_state", state_o, 0);
    @(posedge clk); #1 reset = 1'b0;

    d = '{1, 2, 3, 4, 0, 0, 0, 0};
    attempt(d, 4, 0, p, 0);
    d = '{1, 2, 3, 5, 0, 0, 0, 0};
    repeat (3) attempt(d, 4, 0, p, 0);

    // Inactivity timeout lands exactly TIMEOUT_CYC cycles after the last key event.
    press(1, 2);
    @(posedge clk); #1;
    key_value = 4'd2;
    key_valid = 1'b1;
    @(posedge clk);
    #1 key_valid = 1'b0;
    repeat (TO - 1) @(posedge clk);
    @(negedge clk);
    chk("timeout_not_yet", state_o, 1);
    chk("timeout_count_before", digit_count, 2);
    @(posedge clk);
    @(negedge clk);
    chk("timeout_state", state_o, 0);
    chk("timeout_count", digit_count, 0);
    d = '{1, 2, 3, 4, 0, 0, 0, 0};
    attempt(d, 4, 0, p, 0);

    attempt(d, 4, 2, p, 4);
    attempt(d, 4, 0, p, 0);
    d = '{9, 8, 7, 6, 0, 0, 0, 0};
    attempt(d, 4, 0, p, 0);
    do_reset();
    d = '{1, 2, 3, 4, 0, 0, 0, 0};
    attempt(d, 4, 0, p, 0);

    press(5, 30);
    @(negedge clk);
    chk("hold_count", digit_count, 1);
    chk("hold_state", state_o, 1);
    press(KEY_STAR, 2);
    @(negedge clk);
    chk("star_count", digit_count, 0);
    chk("star_state", state_o, 0);
    d = '{1, 2, 3, 4, 5, 6, 0, 0};
    attempt(d, 6, 0, p, 0);

    d = '{1, 2, 3, 4, 0, 0, 0, 0};
    attempt(d, 4, 3, p, 0);
    d = '{0, 0, 0, 0, 0, 0, 0, 0};
    repeat (3) attempt(d, 4, 3, p, 0);

    for (int t = 0; t < 25; t++) begin
      bit good;
      good = ($urandom_range(0, 2) != 0);
      n = $urandom_range(0, 6);
      for (int i = 0; i < 8; i++) begin
        d[i] = (good && i < PL) ? model_code[i] : $urandom_range(0, 9);
        p[i] = $urandom_range(0, 9);
      end
      act = $urandom_range(0, 2);
      pn  = $urandom_range(0, 6);
      attempt(d, n, act, p, pn);
    end

    repeat (5) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
